// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - decode-stage countdown scoreboard with stall/flush/bubble control
// Optional stall performance counter: HAZARD_STALL_CNT_EN
module hazard_scoreboard #(
    parameter int WB_DIST = 3,
    parameter int CNT_W   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_vld,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [4:0]  id_rd_addr,
    input  logic        id_rd_wren,
    input  logic        br_flush,
    output logic        stall_if,
    output logic        stall_id,
    output logic        flush_id,
    output logic        issue,
    output logic        bubble_ex,
    output logic [31:0] busy_mask,
    output logic [31:0] stall_cycles
);

    logic [CNT_W-1:0] cnt_q [1:31];
    logic [CNT_W-1:0] cnt_d [1:31];
    logic             hazard;

    always_comb begin
        busy_mask    = '0;
        for (int r = 1; r < 32; r++) begin
            busy_mask[r] = (cnt_q[r] != '0);
        end
    end

    // busy_mask[0] is constant 0, so x0 sources can never raise a hazard.
    assign hazard    = id_vld & ((id_rs1_used & busy_mask[id_rs1_addr]) |
                                 (id_rs2_used & busy_mask[id_rs2_addr]));
    assign issue     = id_vld & ~hazard & ~br_flush;
    assign stall_id  = hazard & ~br_flush;
    assign stall_if  = stall_id;
    assign flush_id  = br_flush;
    assign bubble_ex = ~issue;

    always_comb begin
        for (int r = 1; r < 32; r++) begin
            cnt_d[r] = cnt_q[r];
            if (issue && id_rd_wren && (id_rd_addr == 5'(r))) begin
                cnt_d[r] = CNT_W'(WB_DIST);
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 1; r < 32; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 1; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    assign stall_cnt_d = stall_id ? stall_cnt_q + 32'd1 : stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_vld;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic        id_rs1_used, id_rs2_used, id_rd_wren, br_flush;
    logic        stall_if, stall_id, flush_id, issue, bubble_ex;
    logic [31:0] busy_mask, stall_cycles;

    typedef struct packed {
        logic        stall;
        logic        issue;
        logic        flush;
        logic        bubble;
        logic [31:0] busy;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] exp_sc = '0;

    hazard_scoreboard #(.WB_DIST(3), .CNT_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_vld       (id_vld),
        .id_rs1_addr  (id_rs1_addr),
        .id_rs2_addr  (id_rs2_addr),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_rd_addr   (id_rd_addr),
        .id_rd_wren   (id_rd_wren),
        .br_flush     (br_flush),
        .stall_if     (stall_if),
        .stall_id     (stall_id),
        .flush_id     (flush_id),
        .issue        (issue),
        .bubble_ex    (bubble_ex),
        .busy_mask    (busy_mask),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One pipeline cycle: drive ID, queue the expected response, compare at negedge.
    task automatic step(input string tag, input logic vld, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic wren, input logic fl, input logic e_stall,
                        input logic e_issue, input logic [31:0] e_busy);
        exp_t e;
        exp_t got;
        id_vld      = vld;
        id_rs1_addr = rs1;
        id_rs1_used = u1;
        id_rs2_addr = rs2;
        id_rs2_used = u2;
        id_rd_addr  = rd;
        id_rd_wren  = wren;
        br_flush    = fl;
        e.stall  = e_stall;
        e.issue  = e_issue;
        e.flush  = fl;
        e.bubble = ~e_issue;
        e.busy   = e_busy;
        exp_q.push_back(e);
        @(negedge clk);
        got = exp_q.pop_front();
        check({tag, ".stall_if"},     {31'd0, stall_if},  {31'd0, got.stall});
        check({tag, ".stall_id"},     {31'd0, stall_id},  {31'd0, got.stall});
        check({tag, ".issue"},        {31'd0, issue},     {31'd0, got.issue});
        check({tag, ".flush_id"},     {31'd0, flush_id},  {31'd0, got.flush});
        check({tag, ".bubble_ex"},    {31'd0, bubble_ex}, {31'd0, got.bubble});
        check({tag, ".busy_mask"},    busy_mask,          got.busy);
        check({tag, ".stall_cycles"}, stall_cycles,       exp_sc);
`ifdef HAZARD_STALL_CNT_EN
        if (got.stall) exp_sc = exp_sc + 32'd1;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input logic [31:0] e_busy);
        step(tag, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, e_busy);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        id_vld = 1'b1; id_rs1_addr = 5'd5; id_rs1_used = 1'b1;
        id_rs2_addr = 5'd0; id_rs2_used = 1'b0;
        id_rd_addr = 5'd0; id_rd_wren = 1'b0; br_flush = 1'b0;
        #2;
        check("rst.busy_mask",    busy_mask,            32'd0);
        check("rst.stall_id",     {31'd0, stall_id},    32'd0);
        check("rst.issue",        {31'd0, issue},       32'd1);
        check("rst.bubble_ex",    {31'd0, bubble_ex},   32'd0);
        check("rst.stall_cycles", stall_cycles,         32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // add x5 then dependent add x6,x5,x1: three stall cycles
        step("prod_x5", 1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 1, 32'd0);
        step("dep_t1",  1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 1, 0, 32'h20);
        step("dep_t2",  1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 1, 0, 32'h20);
        step("dep_t3",  1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 1, 0, 32'h20);
        step("dep_t4",  1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0, 1, 32'd0);
        idle("x6_c3", 32'h40);
        idle("x6_c2", 32'h40);
        idle("x6_c1", 32'h40);

        // writes to x0 are ignored and x0 reads never stall
        step("addi_x0", 1, 5'd0, 1, 5'd0, 0, 5'd0, 1, 0, 0, 1, 32'd0);
        step("read_x0", 1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 0, 1, 32'd0);

        // flush beats hazard and a flushed instruction never loads the scoreboard
        step("fl_prod",  1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 1, 32'd0);
        step("fl_indep", 1, 5'd2, 1, 5'd0, 0, 5'd0, 0, 0, 0, 1, 32'h20);
        step("fl_kill",  1, 5'd5, 1, 5'd1, 1, 5'd9, 1, 1, 0, 0, 32'h20);
        idle("fl_c1", 32'h20);
        idle("fl_c0", 32'd0);

        // back-to-back writes to x5 restart the countdown
        step("rw_t0", 1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 1, 32'd0);
        step("rw_t1", 1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 1, 32'h20);
        idle("rw_t2", 32'h20);
        idle("rw_t3", 32'h20);
        idle("rw_t4", 32'h20);
        idle("rw_t5", 32'd0);

        // unused rs2 field must not stall; used rs2 does
        step("x7_prod",  1, 5'd1, 1, 5'd2, 1, 5'd7, 1, 0, 0, 1, 32'd0);
        step("itype",    1, 5'd1, 1, 5'd7, 0, 5'd8, 1, 0, 0, 1, 32'h80);
        step("rs2_used", 1, 5'd1, 1, 5'd7, 1, 5'd3, 1, 0, 1, 0, 32'h100 | 32'h80);

        // asynchronous reset in the middle of a stall
        rst = 1'b1;
        #1;
        exp_sc = '0;
        check("mid_rst.busy_mask",    busy_mask,          32'd0);
        check("mid_rst.stall_id",     {31'd0, stall_id},  32'd0);
        check("mid_rst.issue",        {31'd0, issue},     32'd1);
        check("mid_rst.stall_cycles", stall_cycles,       exp_sc);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle("post_rst", 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Decode-stage hazard controller for the non-forwarding 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
- Tracks pending register-file writes with a per-register countdown scoreboard.
- Stalls IF/ID while a source register of the decode instruction is still in flight.
- Injects EX bubbles and honours taken-branch flushes, so the decoder stays purely combinational.

Parameters:
- WB_DIST, 3, cycles from issue (end of ID) until the written value is readable in ID (regfile has no write-through).
- CNT_W, 2, countdown width; must satisfy 2^CNT_W > WB_DIST.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- id_vld  input  1  ID holds a valid decoded instruction (insn_vld from decode, gated by IF/ID valid).
- id_rs1_addr  input  5  rs1 index of ID instruction.
- id_rs2_addr  input  5  rs2 index of ID instruction.
- id_rs1_used  input  1  instruction reads rs1.
- id_rs2_used  input  1  instruction reads rs2 (0 for I-type and loads).
- id_rd_addr  input  5  destination index.
- id_rd_wren  input  1  instruction writes rd.
- br_flush  input  1  taken branch/jump resolved in EX this cycle.
- stall_if  output  1  hold PC and IF/ID register.
- stall_id  output  1  hold ID contents.
- flush_id  output  1  clear IF/ID register at next edge.
- issue  output  1  ID instruction advances into EX at next edge.
- bubble_ex  output  1  load a NOP into ID/EX at next edge.
- busy_mask  output  32  bit r = 1 while register r has a pending write.
- stall_cycles  output  32  stall performance counter (see Optional Feature).

Behaviour:
- State: cnt[1..31], CNT_W bits each. x0 has no counter; busy_mask[0] is always 0.
- Async reset: all cnt = 0 and stall_cycles = 0. All outputs derive from state/inputs, so during reset busy_mask = 0 and stall/issue follow inputs with an empty scoreboard.
- busy_mask[r] = (cnt[r] != 0), decoded from registered state (no input path).
- hazard = id_vld & ((id_rs1_used & rs1 != 0 & busy[rs1]) | (id_rs2_used & rs2 != 0 & busy[rs2])).
- issue = id_vld & ~hazard & ~br_flush.
- stall_if = stall_id = hazard & ~br_flush.
- flush_id = br_flush.
- bubble_ex = ~issue.
- Priority: br_flush overrides hazard. The ID instruction is killed, there is no stall, and fetch redirects.
- Per-cycle update, for each r:
  - if issue & id_rd_wren & id_rd_addr == r & r != 0: cnt[r] <= WB_DIST;
  - else if cnt[r] != 0: cnt[r] <= cnt[r] - 1.
  - The reload wins over the decrement, so a rewrite of a busy register restarts its countdown.
- Timing with WB_DIST = 3:
  - Producer issued at edge t; cnt = 3, 2, 1 in cycles t+1, t+2, t+3; 0 at t+4.
  - A dependent instruction in ID at t+1 stalls in cycles t+1..t+3 and issues at t+4 (3 stall cycles).
  - An independent instruction in ID never stalls.
- A flushed (non-issued) instruction never loads the scoreboard.
- Counters of already-issued instructions keep counting through flushes and stalls; instructions past ID are never flushed.
- id_rd_wren with rd = x0 has no effect.
- A source equal to its own rd is checked against the pre-update state only.
- Mid-operation reset clears every pending entry immediately; the pipeline is reset in the same cycle.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- Defined:
  - stall_cycles increments by 1 on each rising edge where stall_id = 1.
  - Wraps from 0xFFFFFFFF to 0.
  - Cleared by rst.
- Undefined:
  - stall_cycles is tied to 0 and no counter flops are built.
  - The port list is identical in both builds.

Test Plan:
- Reset with id_vld = 1 and rs1 = 5 used -> busy_mask = 0, stall_id = 0, issue = 1, bubble_ex = 0, stall_cycles = 0.
- Issue add x5 at edge t, then add x6,x5,x1 in ID from t+1 -> stall_if/stall_id = 1 and bubble_ex = 1 for 3 cycles; issue = 1 in cycle t+4; busy_mask[5] = 1 for cycles t+1..t+3; stall_cycles = 3 (macro on) or 0 (macro off).
- Issue addi x0,x0,1, then an instruction reading x0 -> busy_mask = 0, no stall.
- x5 busy with cnt = 2, ID reads x5, br_flush = 1 -> stall_id = 0, issue = 0, flush_id = 1, bubble_ex = 1; busy_mask[5] clears 2 cycles later.
- Write x5 at t, write x5 again at t+1 (independent sources) -> cnt[5] reloads to 3; busy_mask[5] stays 1 through t+4 and clears at t+5.
- x7 busy, I-type in ID with rs2 field = 7 and id_rs2_used = 0, rs1 = 1 -> no stall, issue = 1. Assert rst mid-stall -> busy_mask = 0 and stall_id = 0 immediately.
